uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  AXI4-Stream UART receiver; the receive-side counterpart of the UART transmitter.
//  Deserialises 8N1-style frames on rxd (start, DATA_WIDTH bits LSB first, 1 stop),
//  with bit period = prescale*8 clk. Presents each good word on an AXI-Stream master port.
//  Flags overrun and framing errors as 1-cycle pulses.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (1..15)
// PORTS
//  clk                clock
//  rst_n              in   1          async active-low reset
//  output_axi_tdata   out  DATA_WIDTH received word
//  output_axi_tvalid  out  1          word available
//  output_axi_tready  in   1          sink accepts word
//  rxd                in   1          serial line, idle high, asynchronous to clk
//  busy               out  1          frame reception in progress
//  overrun_error      out  1          1-cycle pulse: good word overwrote an unaccepted word
//  frame_error        out  1          1-cycle pulse: stop bit sampled low
//  prescale           in   16         clk per bit / 8; 0 is illegal (receiver stays IDLE)
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous, active-low.
//  Reset values: tdata=0, tvalid=0, busy=0, overrun_error=0, frame_error=0.
//   Sync flops=1, state=IDLE, counter=0.
//  Synchroniser: rxd passes through 2 flops to give rxd_s; all decisions use rxd_s.
//  Timing: 19-bit down-counter. Loading N gives an expiry after N+1 clk (cnt==0).
//   HALF=(prescale<<2)-1, FULL=(prescale<<3)-1.
//  States:
//   IDLE : busy=0. When rxd_s==0 and prescale!=0: load HALF, busy=1, go to START.
//   START: on expiry, sample mid-start bit.
//          rxd_s==0: load FULL, bit_cnt=DATA_WIDTH, go to DATA.
//          rxd_s==1: glitch; go to IDLE with no error and busy=0.
//   DATA : on expiry, shift right with rxd_s entering at the MSB, and decrement bit_cnt.
//          Load FULL. When bit_cnt reaches 0, go to STOP.
//   STOP : on expiry (mid-stop bit):
//          rxd_s==1: tdata<=shift reg, tvalid<=1, go to IDLE with busy=0.
//            overrun_error pulses if tvalid was 1 and not accepted this cycle; old word lost.
//          rxd_s==0: frame_error pulses, word discarded, tvalid unchanged, go to BREAK.
//   BREAK: busy=1. Wait for rxd_s==1, then go to IDLE.
//          Prevents a held-low line or break from retriggering.
//  Handshake: tvalid clears on tvalid&&tready.
//   Accept and new word in the same cycle: tvalid stays 1 with the new data; no overrun.
//   tdata is stable while tvalid=1 and no new word arrives.
//  Return to IDLE at mid-stop allows back-to-back frames with no idle gap.
//  Latency: the rxd falling edge is seen after 2 clk (sync).
//   tvalid rises 2 + 4p + DATA_WIDTH*8p + 8p clk after the rxd edge (p = prescale).
//   Jitter is +-1 clk.
//  prescale is sampled at every counter load. Changing it mid-frame is allowed;
//   the new value takes effect from the next load.
//  Error pulses are exactly 1 clk, and both are 0 in all other cycles.
//  Reset mid-frame: partial word discarded; tvalid=0 immediately.
//   After release, a line still low is treated as a start bit.
// STRUCTURE
//  uart_pkg (shared with the transmitter): state encodings IDLE/START/DATA/STOP/BREAK,
//   localparam OVERSAMPLE=8, and the prescale counter width of 19.
//  Sub-module uart_sync: 2-flop synchroniser with reset value 1 on rst_n.
//   Reused later for CTS/RTS.
//  The rest stays flat: state register, counter, bit_cnt, shift reg, output register.
// TESTING
//  1. Loopback from the transmitter, prescale=1, words 0x55, 0xA5, 0x00, 0xFF with tready=1.
//     -> each word appears once, in order, with no error pulses.
//  2. prescale=2, send 0x3C, tready=0; then send 0x81 and hold tready=0.
//     -> overrun_error=1 for 1 clk at the 2nd stop sample, and tdata=0x81.
//  3. Frame with the stop bit driven low (0x12).
//     -> frame_error pulses once, tvalid stays 0, busy stays 1 until rxd returns high.
//  4. 3-clk low glitch on idle rxd with prescale=4.
//     -> returns to IDLE after 16 clk, no tvalid, no error pulse.
//  5. Back-to-back frames with no idle gap, plus tready toggling every cycle.
//     -> all words received, with tvalid/tdata held stable until accepted.
//  6. Assert rst_n low during DATA of 0x99.
//     -> all outputs reset at once; the next clean frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and timing constants.
// The prescale counter is wide enough for prescale*OVERSAMPLE with a 16-bit prescale.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE     = 8;
  localparam int PRESCALE_CNT_W = 19;
  localparam int BIT_CNT_W      = 4;

endpackage

// File: rtl/uart_rx_if.sv
// AXI4-Stream word channel carrying received UART words to a sink.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous serial-line inputs; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop deserialiser feeding an AXI4-Stream master port.
// Samples each bit at its midpoint using a down-counter reloaded from prescale at every load.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_rx_if.master   output_axi,
  input  logic        rxd,
  output logic        busy,
  output logic        overrun_error,
  output logic        frame_error,
  input  logic [15:0] prescale
);

  uart_state_t               r_state;
  logic [PRESCALE_CNT_W-1:0] r_cnt;
  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_tdata;
  logic                      r_tvalid;
  logic                      r_busy;
  logic                      r_overrun;
  logic                      r_frame;

  logic                      w_rxd_s;
  logic                      w_expired;
  logic [PRESCALE_CNT_W-1:0] w_half;
  logic [PRESCALE_CNT_W-1:0] w_full;
  logic [DATA_WIDTH-1:0]     w_shift_next;

  uart_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rxd),
    .o_q   (w_rxd_s)
  );

  assign w_expired = (r_cnt == '0);
  assign w_half    = PRESCALE_CNT_W'(prescale) * PRESCALE_CNT_W'(OVERSAMPLE / 2) - PRESCALE_CNT_W'(1);
  assign w_full    = PRESCALE_CNT_W'(prescale) * PRESCALE_CNT_W'(OVERSAMPLE) - PRESCALE_CNT_W'(1);

  // LSB-first line: each new bit enters at the MSB and the word shifts toward bit 0
  always_comb begin
    w_shift_next                 = r_shift >> 1;
    w_shift_next[DATA_WIDTH-1]   = w_rxd_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_frame   <= 1'b0;
      if (r_tvalid && output_axi.tready) r_tvalid <= 1'b0;
      if (!w_expired) r_cnt <= r_cnt - PRESCALE_CNT_W'(1);

      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (!w_rxd_s && prescale != 16'd0) begin
            r_cnt   <= w_half;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_expired) begin
            if (!w_rxd_s) begin
              r_cnt     <= w_full;
              r_bit_cnt <= BIT_CNT_W'(DATA_WIDTH);
              r_state   <= ST_DATA;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_expired) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
            r_cnt     <= w_full;
            if (r_bit_cnt == BIT_CNT_W'(1)) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_expired) begin
            if (w_rxd_s) begin
              // a simultaneous accept frees the slot, so only an unaccepted word is lost
              r_tdata   <= r_shift;
              r_tvalid  <= 1'b1;
              r_overrun <= r_tvalid && !output_axi.tready;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_frame <= 1'b1;
              r_state <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          r_busy <= 1'b1;
          if (w_rxd_s) r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign output_axi.tdata  = r_tdata;
  assign output_axi.tvalid = r_tvalid;
  assign busy              = r_busy;
  assign overrun_error     = r_overrun;
  assign frame_error       = r_frame;

endmodule
